// File: rtl/bus_arbiter_if.sv
// Bus-side signal bundle shared by the round-robin arbiter and the requester drivers.
// The master modport is the arbiter; the slave modport is the requester/consumer side.
interface bus_arbiter_if #(
    parameter int N = 4,
    parameter int W = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;
    logic [N*W-1:0] din;
    logic [N-1:0]   en;
    logic [IW-1:0]  gnt_id;
    logic           busy;
    logic           bus_valid;
    logic [W-1:0]   bus_data;

    modport master (
        input  req,
        input  din,
        output en,
        output gnt_id,
        output busy,
        output bus_valid,
        output bus_data
    );

    modport slave (
        output req,
        output din,
        input  en,
        input  gnt_id,
        input  busy,
        input  bus_valid,
        input  bus_data
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared tri-state bus: one-hot driver enables, a one-cycle
// turnaround between owners, a hold limit when others wait, and a registered bus word.
module bus_arbiter #(
    parameter int N        = 4,
    parameter int W        = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.master bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_t;

    state_t         state;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  gnt_q;
    logic [HW-1:0]  hold_cnt;
    logic [N-1:0]   en_q;
    logic           busy_q;
    logic           valid_q;
    logic [W-1:0]   data_q;

    logic           any_req;
    logic           cur_req;
    logic           others_waiting;
    logic           limit_hit;
    logic [IW-1:0]  winner;
    logic [W-1:0]   cur_din;

    // First requester at or after the pointer, wrapping; N is a power of two so the
    // index wraps naturally in IW bits.
    function automatic logic [IW-1:0] pick(input logic [IW-1:0] start, input logic [N-1:0] r);
        logic [IW-1:0] idx;
        logic [IW-1:0] result;
        logic          found;
        result = start;
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = start + IW'(i);
            if (!found && r[idx]) begin
                result = idx;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    assign any_req        = |bus.req;
    assign winner         = pick(ptr, bus.req);
    assign cur_req        = bus.req[gnt_q];
    assign cur_din        = bus.din[gnt_q*W +: W];
    assign others_waiting = |(bus.req & ~(N'(1) << gnt_q));
    assign limit_hit      = (int'(hold_cnt) + 1) >= MAX_HOLD;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt_q    <= '0;
            hold_cnt <= '0;
            en_q     <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            case (state)
                IDLE, TURN: begin
                    valid_q <= 1'b0;
                    if (any_req) begin
                        gnt_q    <= winner;
                        en_q     <= N'(1) << winner;
                        hold_cnt <= '0;
                        busy_q   <= 1'b1;
                        state    <= GRANT;
                    end else begin
                        en_q   <= '0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                GRANT: begin
                    valid_q <= cur_req;
                    if (cur_req) begin
                        data_q <= cur_din;
                        if (int'(hold_cnt) < MAX_HOLD) begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    // A lone requester is never forced off; the limit only applies when someone waits.
                    if (!cur_req || (limit_hit && others_waiting)) begin
                        en_q   <= '0;
                        busy_q <= 1'b0;
                        ptr    <= gnt_q + IW'(1);
                        state  <= TURN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.en        = en_q;
    assign bus.gnt_id    = gnt_q;
    assign bus.busy      = busy_q;
    assign bus.bus_valid = valid_q;
    assign bus.bus_data  = data_q;
endmodule
